// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one ready result source per cycle and
// broadcasts its tag/register/data on a registered CDB. Round-robin or
// fixed-priority selection; consumer back-pressure freezes the bus.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int REG_W   = 3,
    parameter int RR_MODE = 1,
    localparam int SRC_W  = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*REG_W-1:0]  src_reg,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      cdb_stall,
    output logic [NUM_SRC-1:0]        src_grant,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [REG_W-1:0]          cdb_reg,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
);

    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;

    logic [SRC_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [SRC_W:0]    probe;

    // Grant: first requester at or above the search start, wrapping; the start
    // is ptr in round-robin mode and 0 in fixed-priority mode. Payload never enters here.
    always_comb begin
        src_grant = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        probe     = '0;
        if (!cdb_stall) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                probe = (RR_MODE != 0) ? ({1'b0, ptr_q} + (SRC_W+1)'(k)) : (SRC_W+1)'(k);
                if (probe >= (SRC_W+1)'(NUM_SRC)) begin
                    probe = probe - (SRC_W+1)'(NUM_SRC);
                end
                if (!gnt_any && src_req[probe[SRC_W-1:0]]) begin
                    gnt_any                       = 1'b1;
                    gnt_idx                       = probe[SRC_W-1:0];
                    src_grant[probe[SRC_W-1:0]]   = 1'b1;
                end
            end
        end
    end

    // Next bus state: load the winner, drop valid when idle, hold everything on stall.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        reg_d   = reg_q;
        data_d  = data_q;
        src_d   = src_q;
        if (!cdb_stall) begin
            if (gnt_any) begin
                valid_d = 1'b1;
                tag_d   = src_tag[int'(gnt_idx)*TAG_W +: TAG_W];
                reg_d   = src_reg[int'(gnt_idx)*REG_W +: REG_W];
                data_d  = src_data[int'(gnt_idx)*DATA_W +: DATA_W];
                src_d   = gnt_idx;
                if (RR_MODE != 0) begin
                    ptr_d = (gnt_idx == SRC_W'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Bus and pointer registers; reset discards any pending broadcast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_reg   = reg_q;
    assign cdb_data  = data_q;
    assign cdb_src   = src_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of requesting units (reservation-station/FU outputs), legal range 2..16.
REQ-002 Parameter DATA_W, default 16: result data width.
REQ-003 Parameter TAG_W, default 3: reservation-station label (Qi) width.
REQ-004 Parameter REG_W, default 3: destination register index width.
REQ-005 Parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority with index 0 highest.
REQ-006 Clock  input  1  single clock; all state updates on rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 src_req  input  NUM_SRC  per-source request; source i has a result ready.
REQ-009 src_tag  input  NUM_SRC*TAG_W  packed labels; source i occupies bits [i*TAG_W +: TAG_W].
REQ-010 src_reg  input  NUM_SRC*REG_W  packed destination register indices, same packing.
REQ-011 src_data  input  NUM_SRC*DATA_W  packed result data, same packing.
REQ-012 cdb_stall  input  1  consumer back-pressure; when high, no transfer takes place.
REQ-013 src_grant  output  NUM_SRC  one-hot combinational grant; source i's payload is accepted at the next rising edge.
REQ-014 cdb_valid  output  1  registered; the CDB carries a broadcast (busy bit).
REQ-015 cdb_tag, cdb_reg, cdb_data  output  TAG_W, REG_W, DATA_W  registered broadcast payload.
REQ-016 cdb_src  output  clog2(NUM_SRC)  registered index of the source that produced the current broadcast.

Function
REQ-017 Sources shall hold src_req and their payload stable until they see src_grant high at a rising edge; they deassert src_req on the following cycle.
REQ-018 src_grant shall be all-zero when cdb_stall=1 or src_req=0, and otherwise exactly one-hot.
REQ-019 RR_MODE=0: the grant shall go to the lowest-index requesting source.
REQ-020 RR_MODE=1: the grant shall go to the first requesting source found searching upward from pointer ptr, wrapping from NUM_SRC-1 to 0.
REQ-021 On a rising edge where a grant to source i occurs, ptr shall load (i+1) mod NUM_SRC; otherwise ptr shall hold; in RR_MODE=0, ptr shall remain 0.
REQ-022 On a rising edge with grant to source i: cdb_valid<=1, cdb_tag/cdb_reg/cdb_data<=source i's fields, cdb_src<=i.
REQ-023 Latency: a request seen at edge t shall appear on the CDB during cycle t+1, so each broadcast lasts exactly one cycle unless stalled.
REQ-024 On a rising edge with cdb_stall=0 and no request: cdb_valid<=0, and the payload registers hold their values.
REQ-025 On a rising edge with cdb_stall=1: all cdb_* outputs and ptr shall hold, including cdb_valid=1, so an unconsumed broadcast persists.
REQ-026 Back-to-back: with continuous requests and no stall, one grant shall occur every cycle and cdb_valid shall stay high.
REQ-027 Fairness: in RR_MODE=1, a continuously requesting source shall be granted within NUM_SRC cycles of no-stall operation.
REQ-028 src_grant shall depend only on src_req, ptr and cdb_stall; it shall not depend on the payload inputs.

Reset
REQ-029 While Reset=1, regardless of Clock: cdb_valid=0, cdb_tag=0, cdb_reg=0, cdb_data=0, cdb_src=0, ptr=0; src_grant then reflects ptr=0.
REQ-030 Reset asserted mid-broadcast or mid-stall shall discard the broadcast; the first edge after release shall arbitrate normally from ptr=0.

Verification
REQ-031 Single request: NUM_SRC=4, src_req=0010, tag=3, reg=2, data=16'h00A5 -> src_grant=0010 that cycle; next cycle cdb_valid=1, cdb_tag=3, cdb_reg=2, cdb_data=16'h00A5, cdb_src=1; the following cycle cdb_valid=0.
REQ-032 Round-robin rotation: RR_MODE=1, src_req=1111 held for 5 cycles -> grants 0001, 0010, 0100, 1000, 0001; cdb_src sequence 0,1,2,3,0 with cdb_valid continuously 1.
REQ-033 Fixed priority: RR_MODE=0, src_req=1010 held -> grant 0010 every cycle while source 1 keeps requesting; source 3 is granted only after source 1 drops its request.
REQ-034 Stall: broadcast from source 2 (data 16'h1234) valid, cdb_stall=1 for 3 cycles with src_req=0001 -> src_grant=0000, cdb outputs frozen at source 2/16'h1234; on the first edge after the stall is released, source 0 is granted.
REQ-035 Wrap: RR_MODE=1, after a grant to source 3 (ptr=0), src_req=1001 -> source 0 is granted, then source 3.
REQ-036 Async reset: assert Reset between edges while cdb_valid=1 -> cdb_valid=0 and all outputs 0 immediately; after release, src_req=1100 -> source 2 is granted first.
